triangle_setup: RTL and testbench
=================================

TRIANGLE_SETUP -- requirements
Module: triangle_setup

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  SCREEN_W  640  screen width in pixels
  SCREEN_H  480  screen height in pixels
  CULL_BACKFACE  1  1 = drop triangles with negative area
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 srst  in  1  reset, synchronous, active-high.
REQ-004 in_valid  in  1  triangle from vertex shader valid; in_ready  out  1  accept.
REQ-005 x1,y1,x2,y2,x3,y3  in  12 each  unsigned screen coordinates, pixels.
REQ-006 depth1..3  in  21 each  vertex depth; color1..3  in  24 each  vertex color.
REQ-007 out_valid  out  1  setup result valid; out_ready  in  1  downstream rasterizer accepts.
REQ-008 a0,a1,a2  out  13 each, signed  edge x-coefficients.
REQ-009 b0,b1,b2  out  13 each, signed  edge y-coefficients.
REQ-010 c0,c1,c2  out  25 each, signed  edge constants.
REQ-011 area2  out  27 signed  twice the signed triangle area.
REQ-012 bb_xmin,bb_xmax,bb_ymin,bb_ymax  out  12 each  clamped bounding box.
REQ-013 depth1..3_o (21), color1..3_o (24)  out  captured vertex attributes, passed through.
REQ-014 cull_cnt  out  16  count of dropped triangles, saturating at 0xFFFF.

Function
REQ-015 States: IDLE, EDGE0, EDGE1, EDGE2, FINAL, OUT.
REQ-016 in_ready = 1 only in IDLE; a transfer occurs when in_valid & in_ready; all inputs are registered at that edge and the FSM goes to EDGE0.
REQ-017 EDGE0/1/2 each compute one edge per cycle using one shared coefficient unit; transitions EDGE0->EDGE1->EDGE2->FINAL are unconditional.
REQ-018 Edge k runs from vertex (j) to vertex (m): edge0 v1->v2, edge1 v2->v3, edge2 v3->v1. Coefficients: a = yj - ym, b = xm - xj, c = xj*ym - xm*yj. Products are 24-bit unsigned; c is a 25-bit signed exact difference.
REQ-019 FINAL: area2 = c0 + c1 + c2 (exact, 27-bit signed). Bounding box = min/max of the vertex coordinates, with max clamped to SCREEN_W-1 / SCREEN_H-1.
REQ-020 Cull in FINAL if any of these holds: area2 == 0; CULL_BACKFACE == 1 and area2 < 0; unclamped xmin > SCREEN_W-1; unclamped ymin > SCREEN_H-1.
REQ-021 A culled triangle goes FINAL->IDLE, cull_cnt increments (saturating), and out_valid is never asserted for it.
REQ-022 A non-culled triangle goes FINAL->OUT. out_valid is 1 in OUT only. If the input is accepted at edge T, out_valid is high after edge T+4.
REQ-023 In OUT, all outputs are held stable while out_ready = 0. When out_valid & out_ready, the FSM goes to IDLE on that edge.
REQ-024 No new triangle is accepted before the previous one is emitted or culled. Throughput is at most one triangle per 6 cycles.
REQ-025 Output data registers keep their last value outside OUT; only out_valid qualifies them.

Reset
REQ-026 srst has priority over all other inputs. It forces state = IDLE, out_valid = 0, in_ready = 1 on the next cycle, cull_cnt = 0, and all coefficient, bounding-box and attribute outputs = 0.
REQ-027 srst asserted mid-operation (any state) discards the in-flight triangle. No partial result is emitted.

Structure
REQ-028 Shared package render_pkg holds: coordinate width 12, depth width 21, color width 24, coefficient widths 13/25/27, and the state encoding.
REQ-029 One combinational sub-module, edge_coef_unit: inputs are two vertices, outputs are a, b, c. It is instantiated once and time-multiplexed across EDGE0..2.

Verification
REQ-030 (10,10),(20,10),(10,20) -> a=(0,-10,10), b=(10,-10,0), c=(-100,300,-100), area2=100, bbox x10..20, y10..20; out_valid 4 cycles after accept.
REQ-031 (10,10),(10,20),(20,10) -> area2=-100: with CULL_BACKFACE=1 no out_valid and cull_cnt=1; with CULL_BACKFACE=0 emitted with area2=-100.
REQ-032 Collinear (0,0),(5,5),(10,10) -> culled, cull_cnt increments, FSM back in IDLE (in_ready=1) the cycle after FINAL.
REQ-033 (600,400),(700,470),(650,500) at 640x480 -> area2=6500, bb_xmax=639, bb_ymax=479, bb_xmin=600, bb_ymin=400.
REQ-034 out_ready held 0 for 3 cycles in OUT -> out_valid and all outputs stable, in_ready=0. Then out_ready=1 -> handshake completes, in_ready=1 next cycle.
REQ-035 srst pulsed while in EDGE1 -> next cycle state IDLE, out_valid=0, cull_cnt=0. A following triangle is processed normally.

Source files
------------

// File: rtl/render_pkg.sv
// Shared widths, FSM encoding and small helpers for the triangle setup stage.
package render_pkg;
   localparam int COORD_W   = 12;
   localparam int DEPTH_W   = 21;
   localparam int COLOR_W   = 24;
   localparam int COEF_AB_W = 13;
   localparam int COEF_C_W  = 25;
   localparam int AREA_W    = 27;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_EDGE0 = 3'd1,
      S_EDGE1 = 3'd2,
      S_EDGE2 = 3'd3,
      S_FINAL = 3'd4,
      S_OUT   = 3'd5
   } state_t;

   function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] p, q, r);
      logic [COORD_W-1:0] m;
      m = (p < q) ? p : q;
      return (m < r) ? m : r;
   endfunction

   function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] p, q, r);
      logic [COORD_W-1:0] m;
      m = (p > q) ? p : q;
      return (m > r) ? m : r;
   endfunction
endpackage

// File: rtl/edge_coef_unit.sv
// Edge equation coefficients for the directed edge from vertex j to vertex m.
module edge_coef_unit
   import render_pkg::*;
(
   input  logic [COORD_W-1:0]          xj,
   input  logic [COORD_W-1:0]          yj,
   input  logic [COORD_W-1:0]          xm,
   input  logic [COORD_W-1:0]          ym,
   output logic signed [COEF_AB_W-1:0] a,
   output logic signed [COEF_AB_W-1:0] b,
   output logic signed [COEF_C_W-1:0]  c
);
   logic [2*COORD_W-1:0] p_jm;
   logic [2*COORD_W-1:0] p_mj;

   assign p_jm = {{COORD_W{1'b0}}, xj} * {{COORD_W{1'b0}}, ym};
   assign p_mj = {{COORD_W{1'b0}}, xm} * {{COORD_W{1'b0}}, yj};

   assign a = $signed({1'b0, yj}) - $signed({1'b0, ym});
   assign b = $signed({1'b0, xm}) - $signed({1'b0, xj});
   assign c = $signed({1'b0, p_jm}) - $signed({1'b0, p_mj});
endmodule

// File: rtl/triangle_setup.sv
// Triangle setup: edge coefficients, signed area, clamped bounding box and culling.
//
// state   | meaning
// S_IDLE  | waiting for a triangle, in_ready high
// S_EDGE0 | edge v1->v2 through the shared coefficient unit
// S_EDGE1 | edge v2->v3
// S_EDGE2 | edge v3->v1
// S_FINAL | area, bounding box, cull decision; results latched if kept
// S_OUT   | out_valid high, waiting for out_ready
module triangle_setup
   import render_pkg::*;
#(
   parameter int SCREEN_W      = 640,
   parameter int SCREEN_H      = 480,
   parameter int CULL_BACKFACE = 1
) (
   input  logic                        clk,
   input  logic                        srst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [COORD_W-1:0]          x1,
   input  logic [COORD_W-1:0]          y1,
   input  logic [COORD_W-1:0]          x2,
   input  logic [COORD_W-1:0]          y2,
   input  logic [COORD_W-1:0]          x3,
   input  logic [COORD_W-1:0]          y3,
   input  logic [DEPTH_W-1:0]          depth1,
   input  logic [DEPTH_W-1:0]          depth2,
   input  logic [DEPTH_W-1:0]          depth3,
   input  logic [COLOR_W-1:0]          color1,
   input  logic [COLOR_W-1:0]          color2,
   input  logic [COLOR_W-1:0]          color3,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [COEF_AB_W-1:0] a0,
   output logic signed [COEF_AB_W-1:0] a1,
   output logic signed [COEF_AB_W-1:0] a2,
   output logic signed [COEF_AB_W-1:0] b0,
   output logic signed [COEF_AB_W-1:0] b1,
   output logic signed [COEF_AB_W-1:0] b2,
   output logic signed [COEF_C_W-1:0]  c0,
   output logic signed [COEF_C_W-1:0]  c1,
   output logic signed [COEF_C_W-1:0]  c2,
   output logic signed [AREA_W-1:0]    area2,
   output logic [COORD_W-1:0]          bb_xmin,
   output logic [COORD_W-1:0]          bb_xmax,
   output logic [COORD_W-1:0]          bb_ymin,
   output logic [COORD_W-1:0]          bb_ymax,
   output logic [DEPTH_W-1:0]          depth1_o,
   output logic [DEPTH_W-1:0]          depth2_o,
   output logic [DEPTH_W-1:0]          depth3_o,
   output logic [COLOR_W-1:0]          color1_o,
   output logic [COLOR_W-1:0]          color2_o,
   output logic [COLOR_W-1:0]          color3_o,
   output logic [15:0]                 cull_cnt
);
   localparam logic [COORD_W-1:0] XMAX = COORD_W'(SCREEN_W - 1);
   localparam logic [COORD_W-1:0] YMAX = COORD_W'(SCREEN_H - 1);

   state_t state, state_nxt;

   logic [COORD_W-1:0]          vx [3];
   logic [COORD_W-1:0]          vy [3];
   logic [DEPTH_W-1:0]          vd [3];
   logic [COLOR_W-1:0]          vc [3];
   logic signed [COEF_AB_W-1:0] wa [3];
   logic signed [COEF_AB_W-1:0] wb [3];
   logic signed [COEF_C_W-1:0]  wc [3];

   logic [COORD_W-1:0]          ej_x, ej_y, em_x, em_y;
   logic signed [COEF_AB_W-1:0] ea, eb;
   logic signed [COEF_C_W-1:0]  ec;
   logic signed [AREA_W-1:0]    area_w;
   logic [COORD_W-1:0]          xmin_u, xmax_u, ymin_u, ymax_u;
   logic                        cull;

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_OUT);

   always_comb begin
      ej_x = vx[0];
      ej_y = vy[0];
      em_x = vx[1];
      em_y = vy[1];
      case (state)
         S_EDGE1: begin ej_x = vx[1]; ej_y = vy[1]; em_x = vx[2]; em_y = vy[2]; end
         S_EDGE2: begin ej_x = vx[2]; ej_y = vy[2]; em_x = vx[0]; em_y = vy[0]; end
         default: ;
      endcase
   end

   edge_coef_unit u_edge (
      .xj (ej_x),
      .yj (ej_y),
      .xm (em_x),
      .ym (em_y),
      .a  (ea),
      .b  (eb),
      .c  (ec)
   );

   // Cull on the unclamped minimum so a fully off-screen triangle is dropped.
   always_comb begin
      area_w = {{2{wc[0][COEF_C_W-1]}}, wc[0]}
             + {{2{wc[1][COEF_C_W-1]}}, wc[1]}
             + {{2{wc[2][COEF_C_W-1]}}, wc[2]};
      xmin_u = min3(vx[0], vx[1], vx[2]);
      xmax_u = max3(vx[0], vx[1], vx[2]);
      ymin_u = min3(vy[0], vy[1], vy[2]);
      ymax_u = max3(vy[0], vy[1], vy[2]);
      cull   = (area_w == '0)
            || ((CULL_BACKFACE != 0) && area_w[AREA_W-1])
            || (xmin_u > XMAX)
            || (ymin_u > YMAX);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (in_valid) state_nxt = S_EDGE0;
         S_EDGE0: state_nxt = S_EDGE1;
         S_EDGE1: state_nxt = S_EDGE2;
         S_EDGE2: state_nxt = S_FINAL;
         S_FINAL: state_nxt = cull ? S_IDLE : S_OUT;
         S_OUT:   if (out_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (srst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         for (int i = 0; i < 3; i++) begin
            vx[i] <= '0; vy[i] <= '0; vd[i] <= '0; vc[i] <= '0;
            wa[i] <= '0; wb[i] <= '0; wc[i] <= '0;
         end
         a0 <= '0; a1 <= '0; a2 <= '0;
         b0 <= '0; b1 <= '0; b2 <= '0;
         c0 <= '0; c1 <= '0; c2 <= '0;
         area2    <= '0;
         bb_xmin  <= '0; bb_xmax <= '0; bb_ymin <= '0; bb_ymax <= '0;
         depth1_o <= '0; depth2_o <= '0; depth3_o <= '0;
         color1_o <= '0; color2_o <= '0; color3_o <= '0;
         cull_cnt <= '0;
      end else begin
         if (state == S_IDLE && in_valid) begin
            vx[0] <= x1; vy[0] <= y1; vd[0] <= depth1; vc[0] <= color1;
            vx[1] <= x2; vy[1] <= y2; vd[1] <= depth2; vc[1] <= color2;
            vx[2] <= x3; vy[2] <= y3; vd[2] <= depth3; vc[2] <= color3;
         end
         case (state)
            S_EDGE0: begin wa[0] <= ea; wb[0] <= eb; wc[0] <= ec; end
            S_EDGE1: begin wa[1] <= ea; wb[1] <= eb; wc[1] <= ec; end
            S_EDGE2: begin wa[2] <= ea; wb[2] <= eb; wc[2] <= ec; end
            S_FINAL: begin
               if (cull) begin
                  if (cull_cnt != 16'hFFFF) cull_cnt <= cull_cnt + 16'd1;
               end else begin
                  // Visible outputs change only when a kept triangle is latched.
                  a0 <= wa[0]; a1 <= wa[1]; a2 <= wa[2];
                  b0 <= wb[0]; b1 <= wb[1]; b2 <= wb[2];
                  c0 <= wc[0]; c1 <= wc[1]; c2 <= wc[2];
                  area2    <= area_w;
                  bb_xmin  <= xmin_u;
                  bb_ymin  <= ymin_u;
                  bb_xmax  <= (xmax_u > XMAX) ? XMAX : xmax_u;
                  bb_ymax  <= (ymax_u > YMAX) ? YMAX : ymax_u;
                  depth1_o <= vd[0]; depth2_o <= vd[1]; depth3_o <= vd[2];
                  color1_o <= vc[0]; color2_o <= vc[1]; color3_o <= vc[2];
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_triangle_setup.sv
// Directed bench for triangle_setup: vector table plus stall, reset and no-cull sequences.
module tb_triangle_setup;
   logic clk = 1'b0;
   logic srst, in_valid, in_ready, out_valid, out_ready;
   logic [11:0] x1, y1, x2, y2, x3, y3;
   logic [20:0] depth1, depth2, depth3, depth1_o, depth2_o, depth3_o;
   logic [23:0] color1, color2, color3, color1_o, color2_o, color3_o;
   logic signed [12:0] a0, a1, a2, b0, b1, b2;
   logic signed [24:0] c0, c1, c2;
   logic signed [26:0] area2;
   logic [11:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;
   logic [15:0] cull_cnt;

   logic nb_in_valid, nb_in_ready, nb_out_valid;
   logic signed [12:0] nb_a0, nb_a1, nb_a2, nb_b0, nb_b1, nb_b2;
   logic signed [24:0] nb_c0, nb_c1, nb_c2;
   logic signed [26:0] nb_area2;
   logic [11:0] nb_xmin, nb_xmax, nb_ymin, nb_ymax;
   logic [20:0] nb_d1, nb_d2, nb_d3;
   logic [23:0] nb_col1, nb_col2, nb_col3;
   logic [15:0] nb_cull_cnt;

   always #5 clk = ~clk;

   triangle_setup #(.SCREEN_W(640), .SCREEN_H(480), .CULL_BACKFACE(1)) dut (
      .clk(clk), .srst(srst), .in_valid(in_valid), .in_ready(in_ready),
      .x1(x1), .y1(y1), .x2(x2), .y2(y2), .x3(x3), .y3(y3),
      .depth1(depth1), .depth2(depth2), .depth3(depth3),
      .color1(color1), .color2(color2), .color3(color3),
      .out_valid(out_valid), .out_ready(out_ready),
      .a0(a0), .a1(a1), .a2(a2), .b0(b0), .b1(b1), .b2(b2),
      .c0(c0), .c1(c1), .c2(c2), .area2(area2),
      .bb_xmin(bb_xmin), .bb_xmax(bb_xmax), .bb_ymin(bb_ymin), .bb_ymax(bb_ymax),
      .depth1_o(depth1_o), .depth2_o(depth2_o), .depth3_o(depth3_o),
      .color1_o(color1_o), .color2_o(color2_o), .color3_o(color3_o),
      .cull_cnt(cull_cnt)
   );

   triangle_setup #(.SCREEN_W(640), .SCREEN_H(480), .CULL_BACKFACE(0)) dut_nb (
      .clk(clk), .srst(srst), .in_valid(nb_in_valid), .in_ready(nb_in_ready),
      .x1(x1), .y1(y1), .x2(x2), .y2(y2), .x3(x3), .y3(y3),
      .depth1(depth1), .depth2(depth2), .depth3(depth3),
      .color1(color1), .color2(color2), .color3(color3),
      .out_valid(nb_out_valid), .out_ready(out_ready),
      .a0(nb_a0), .a1(nb_a1), .a2(nb_a2), .b0(nb_b0), .b1(nb_b1), .b2(nb_b2),
      .c0(nb_c0), .c1(nb_c1), .c2(nb_c2), .area2(nb_area2),
      .bb_xmin(nb_xmin), .bb_xmax(nb_xmax), .bb_ymin(nb_ymin), .bb_ymax(nb_ymax),
      .depth1_o(nb_d1), .depth2_o(nb_d2), .depth3_o(nb_d3),
      .color1_o(nb_col1), .color2_o(nb_col2), .color3_o(nb_col3),
      .cull_cnt(nb_cull_cnt)
   );

   typedef struct {
      int x1, y1, x2, y2, x3, y3;
      int cull;
      int a0, a1, a2, b0, b1, b2, c0, c1, c2;
      int area;
      int xmin, xmax, ymin, ymax;
   } vec_t;

   vec_t vecs [9];
   int checks = 0;
   int errors = 0;
   int exp_cull = 0;
   int last_area = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_tri(input vec_t v, input int idx);
      x1 = 12'(v.x1); y1 = 12'(v.y1);
      x2 = 12'(v.x2); y2 = 12'(v.y2);
      x3 = 12'(v.x3); y3 = 12'(v.y3);
      depth1 = 21'(idx * 16 + 1); depth2 = 21'(idx * 16 + 2); depth3 = 21'(idx * 16 + 3);
      color1 = 24'(idx * 256 + 24'h100000);
      color2 = 24'(idx * 256 + 24'h200000);
      color3 = 24'(idx * 256 + 24'h300000);
   endtask

   // Accept at edge T and check out_valid stays low through edge T+3; returns after edge T+4.
   task automatic start_tri(input vec_t v, input int idx);
      drive_tri(v, idx);
      chk("pre_in_ready", in_ready, 1);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk("latency_out_valid_low", out_valid, 0);
      end
      tick();
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      start_tri(v, idx);
      if (v.cull != 0) begin
         exp_cull++;
         chk("cull_out_valid", out_valid, 0);
         chk("cull_in_ready", in_ready, 1);
         chk("cull_cnt", cull_cnt, exp_cull);
         chk("cull_area2_held", area2, last_area);
      end else begin
         chk("out_valid", out_valid, 1);
         chk("out_in_ready", in_ready, 0);
         chk("a0", a0, v.a0); chk("a1", a1, v.a1); chk("a2", a2, v.a2);
         chk("b0", b0, v.b0); chk("b1", b1, v.b1); chk("b2", b2, v.b2);
         chk("c0", c0, v.c0); chk("c1", c1, v.c1); chk("c2", c2, v.c2);
         chk("area2", area2, v.area);
         chk("bb_xmin", bb_xmin, v.xmin); chk("bb_xmax", bb_xmax, v.xmax);
         chk("bb_ymin", bb_ymin, v.ymin); chk("bb_ymax", bb_ymax, v.ymax);
         chk("depth2_o", depth2_o, idx * 16 + 2);
         chk("color3_o", color3_o, idx * 256 + 24'h300000);
         chk("cull_cnt_kept", cull_cnt, exp_cull);
         last_area = v.area;
         tick();
         chk("handshake_in_ready", in_ready, 1);
         chk("handshake_out_valid", out_valid, 0);
      end
   endtask

   initial begin
      //          x1   y1   x2   y2   x3   y3  cull a0   a1    a2   b0    b1    b2  c0     c1        c2     area      xmin xmax ymin ymax
      vecs[0] = '{10,  10,  20,  10,  10,  20,  0,  0,  -10,  10,  10,  -10,  0,  -100,  300,      -100,  100,      10,  20,  10,  20};
      vecs[1] = '{10,  10,  10,  20,  20,  10,  1,  0,  0,    0,   0,   0,    0,  0,     0,        0,     0,        0,   0,   0,   0};
      vecs[2] = '{0,   0,   5,   5,   10,  10,  1,  0,  0,    0,   0,   0,    0,  0,     0,        0,     0,        0,   0,   0,   0};
      vecs[3] = '{600, 400, 700, 470, 650, 500, 0,  -70, -30, 100, 100, -50,  -50, 2000, 44500,    -40000, 6500,    600, 639, 400, 479};
      vecs[4] = '{700, 10,  800, 10,  700, 50,  1,  0,  0,    0,   0,   0,    0,  0,     0,        0,     0,        0,   0,   0,   0};
      vecs[5] = '{0,   0,   4095, 0,  0,   4095, 0, 0,  -4095, 4095, 4095, -4095, 0, 0,    16769025, 0,     16769025, 0,   639, 0,   479};
      vecs[6] = '{0,   0,   0,   4095, 4095, 0, 1,  0,  0,    0,   0,   0,    0,  0,     0,        0,     0,        0,   0,   0,   0};
      vecs[7] = '{10,  480, 20,  480, 10,  490, 1,  0,  0,    0,   0,   0,    0,  0,     0,        0,     0,        0,   0,   0,   0};
      vecs[8] = '{10,  479, 20,  479, 10,  489, 0,  0,  -10,  10,  10,  -10,  0,  -4790, 4990,     -100,  100,      10,  20,  479, 479};

      srst = 1'b1; in_valid = 1'b0; nb_in_valid = 1'b0; out_ready = 1'b1;
      drive_tri(vecs[0], 0);
      tick(); tick();
      srst = 1'b0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_cull_cnt", cull_cnt, 0);
      chk("rst_area2", area2, 0);
      chk("rst_bb_xmax", bb_xmax, 0);
      chk("rst_depth1_o", depth1_o, 0);

      for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

      // Back-facing triangle is emitted when culling of negative area is disabled.
      drive_tri(vecs[1], 1);
      nb_in_valid = 1'b1;
      tick();
      nb_in_valid = 1'b0;
      repeat (4) tick();
      chk("nb_out_valid", nb_out_valid, 1);
      chk("nb_area2", nb_area2, -100);
      chk("nb_a0", nb_a0, -10);
      chk("nb_c1", nb_c1, -300);
      chk("nb_cull_cnt", nb_cull_cnt, 0);
      tick();
      chk("nb_in_ready", nb_in_ready, 1);

      // Downstream stall in OUT.
      out_ready = 1'b0;
      start_tri(vecs[0], 20);
      for (int k = 0; k < 3; k++) begin
         chk("stall_out_valid", out_valid, 1);
         chk("stall_in_ready", in_ready, 0);
         chk("stall_area2", area2, 100);
         chk("stall_a1", a1, -10);
         chk("stall_bb_xmax", bb_xmax, 20);
         chk("stall_depth1_o", depth1_o, 20 * 16 + 1);
         tick();
      end
      chk("stall_end_out_valid", out_valid, 1);
      out_ready = 1'b1;
      tick();
      chk("stall_release_in_ready", in_ready, 1);
      chk("stall_release_out_valid", out_valid, 0);
      last_area = 100;

      // Reset while the FSM sits in EDGE1.
      drive_tri(vecs[3], 30);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      srst = 1'b1;
      tick();
      srst = 1'b0;
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_cull_cnt", cull_cnt, 0);
      chk("mid_rst_area2", area2, 0);
      chk("mid_rst_bb_xmax", bb_xmax, 0);
      exp_cull = 0;
      last_area = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("mid_rst_no_emit", out_valid, 0);
      end
      run_vec(vecs[0], 40);
      run_vec(vecs[2], 41);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
